// File: rtl/bru_pkg.sv
// Shared definitions for the branch-history predictor: 2-bit counter
// encodings and the saturating next-state rule used for training and bypass.
package bru_pkg;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = BHT_WNT;

    // Move one step toward taken (inc=1) or not-taken (inc=0), sticking at the ends.
    function automatic bht_state_e bht_next_state(input bht_state_e cur, input logic inc);
        bht_state_e nxt;
        nxt = cur;
        if (inc) begin
            if (cur != BHT_ST) begin
                nxt = bht_state_e'(cur + 2'd1);
            end
        end else begin
            if (cur != BHT_SNT) begin
                nxt = bht_state_e'(cur - 2'd1);
            end
        end
        return nxt;
    endfunction

    function automatic logic bht_predict(input bht_state_e cur);
        return cur[1];
    endfunction

endpackage

// File: rtl/bru_sat_counter.sv
// One 2-bit saturating direction counter; one instance per table entry.
module bru_sat_counter
    import bru_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       en_in,
    input  logic       inc_in,
    output logic [1:0] state_out
);

    bht_state_e state_reg;
    bht_state_e state_next;

    always_comb begin
        state_next = state_reg;
        if (en_in) begin
            state_next = bht_next_state(state_reg, inc_in);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= BHT_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state_out = state_reg;

endmodule

// File: rtl/bru_bht.sv
// Branch history table: bimodal or gshare-indexed 2-bit counters, trained by
// BRU feedback, with saturating lookup and misprediction statistics.
module bru_bht
    import bru_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int GSHARE   = 0,
    parameter int GHR_BITS = 6,
    parameter int CNT_W    = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                pred_valid_in,
    input  logic [XLEN-1:0]     pred_pc_in,
    output logic                pred_valid_out,
    output logic                pred_taken_out,
    output logic [IDX_BITS-1:0] pred_idx_out,
    input  logic                upd_en_in,
    input  logic [IDX_BITS-1:0] upd_idx_in,
    input  logic                upd_taken_in,
    input  logic                upd_mispredict_in,
    output logic [CNT_W-1:0]    lookups_out,
    output logic [CNT_W-1:0]    mispred_out
);

    localparam int NUM_ENTRIES = 1 << IDX_BITS;

    generate
        if (GHR_BITS < 1 || GHR_BITS > IDX_BITS) begin : g_bad_ghr
            $error("bru_bht: GHR_BITS must be within 1..IDX_BITS");
        end
    endgenerate

    logic [IDX_BITS-1:0] base_idx;
    logic [IDX_BITS-1:0] lookup_idx;
    logic [GHR_BITS-1:0] ghr_reg;
    logic [GHR_BITS-1:0] ghr_next;
    logic [GHR_BITS-1:0] ghr_shifted;
    logic [1:0]          cnt_state [NUM_ENTRIES];
    bht_state_e          lookup_state;
    bht_state_e          lookup_state_fwd;

    logic                pred_valid_reg;
    logic                pred_taken_reg;
    logic [IDX_BITS-1:0] pred_idx_reg;
    logic                pred_taken_next;
    logic [CNT_W-1:0]    lookups_reg;
    logic [CNT_W-1:0]    lookups_next;
    logic [CNT_W-1:0]    mispred_reg;
    logic [CNT_W-1:0]    mispred_next;

    // Only the word-aligned index field of the PC participates in the lookup.
    assign base_idx = pred_pc_in[IDX_BITS+1:2];

    generate
        if (XLEN > IDX_BITS + 2) begin : g_pc_hi
            logic unused_pc_bits;
            assign unused_pc_bits = ^{pred_pc_in[XLEN-1:IDX_BITS+2], pred_pc_in[1:0]};
        end else begin : g_pc_lo
            logic unused_pc_bits;
            assign unused_pc_bits = ^pred_pc_in[1:0];
        end
    endgenerate

    generate
        if (GSHARE != 0) begin : g_gshare
            assign lookup_idx = base_idx ^ IDX_BITS'(ghr_reg);
        end else begin : g_bimodal
            assign lookup_idx = base_idx;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cnt
            bru_sat_counter u_cnt (
                .clk_in    (clk_in),
                .rst_in    (rst_in),
                .en_in     (upd_en_in && (upd_idx_in == IDX_BITS'(gi))),
                .inc_in    (upd_taken_in),
                .state_out (cnt_state[gi])
            );
        end
    endgenerate

    // Write-first: a same-cycle update to the looked-up entry is forwarded.
    always_comb begin
        lookup_state     = bht_state_e'(cnt_state[lookup_idx]);
        lookup_state_fwd = lookup_state;
        if (upd_en_in && (upd_idx_in == lookup_idx)) begin
            lookup_state_fwd = bht_next_state(lookup_state, upd_taken_in);
        end
        pred_taken_next = bht_predict(lookup_state_fwd);
    end

    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign ghr_shifted = upd_taken_in;
        end else begin : g_ghr_multi
            assign ghr_shifted = {ghr_reg[GHR_BITS-2:0], upd_taken_in};
        end
    endgenerate

    // History only advances on resolved branches, so it is never speculative.
    always_comb begin
        ghr_next = ghr_reg;
        if (upd_en_in) begin
            ghr_next = ghr_shifted;
        end
    end

    always_comb begin
        lookups_next = lookups_reg;
        if (pred_valid_in && (lookups_reg != {CNT_W{1'b1}})) begin
            lookups_next = lookups_reg + CNT_W'(1);
        end
        mispred_next = mispred_reg;
        if (upd_en_in && upd_mispredict_in && (mispred_reg != {CNT_W{1'b1}})) begin
            mispred_next = mispred_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_idx_reg   <= '0;
            ghr_reg        <= '0;
            lookups_reg    <= '0;
            mispred_reg    <= '0;
        end else begin
            pred_valid_reg <= pred_valid_in;
            if (pred_valid_in) begin
                pred_taken_reg <= pred_taken_next;
                pred_idx_reg   <= lookup_idx;
            end
            ghr_reg     <= ghr_next;
            lookups_reg <= lookups_next;
            mispred_reg <= mispred_next;
        end
    end

    assign pred_valid_out = pred_valid_reg;
    assign pred_taken_out = pred_taken_reg;
    assign pred_idx_out   = pred_idx_reg;
    assign lookups_out    = lookups_reg;
    assign mispred_out    = mispred_reg;

endmodule
